lsu_mem_initiator: RTL and testbench



---
 rtl/lsu_pkg.sv | 13 +
 rtl/lsu_align_decode.sv | 22 ++
 rtl/lsu_mem_initiator.sv | 122 ++++++++++++
 tb/tb_lsu_mem_initiator.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM states, funct3 codes and sign_mask encodings for the LSU initiator
package lsu_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE_R, S_CAPT, S_ISSUE_W, S_WAIT_W, S_RESP} state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] SM_BYTE = 3'b001;
  localparam logic [2:0] SM_HALF = 3'b011;
  localparam logic [2:0] SM_WORD = 3'b111;
  localparam int SM_SIGNED = 3;
endpackage

// File: rtl/lsu_align_decode.sv
// lsu_align_decode: funct3/addr[1:0]/we -> data_mem sign_mask plus illegal/misaligned error
module lsu_align_decode
  import lsu_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic [1:0] addr_i,
  input  logic       we_i,
  output logic [3:0] sign_mask_o,
  output logic       err_o
);
  logic [2:0] sz;
  logic       illegal;
  logic       mis;
  always_comb begin
    sz = funct3_i[1:0] == 2'b00 ? SM_BYTE : funct3_i[1:0] == 2'b01 ? SM_HALF : SM_WORD;
    illegal = funct3_i[1:0] == 2'b11 || (funct3_i[2] && (we_i || funct3_i[1]));
    mis = (sz == SM_HALF && addr_i[0]) || (sz == SM_WORD && addr_i != 2'b00);
    sign_mask_o = 4'(sz);
    sign_mask_o[SM_SIGNED] = !we_i && (funct3_i == F3_B || funct3_i == F3_H);
    err_o = illegal || mis;
  end
endmodule

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: one-at-a-time load/store initiator driving data_mem with single-cycle strobes
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int STALL_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_sign_mask,
  output logic        mem_memread,
  output logic        mem_memwrite,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);
  localparam int CW = $clog2(STALL_TIMEOUT + 1);
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          seen_q, seen_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]    mask_q, mask_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic [3:0]    dec_mask;
  logic          dec_err, done, timeout;
  lsu_align_decode u_dec (
    .funct3_i   (req_funct3),
    .addr_i     (req_addr[1:0]),
    .we_i       (req_we),
    .sign_mask_o(dec_mask),
    .err_o      (dec_err)
  );
  // The write is finished once the memory has raised and then dropped clk_stall
  assign done    = state_q == S_WAIT_W && seen_q && !mem_clk_stall;
  assign timeout = state_q == S_WAIT_W && !done && cnt_q == CW'(STALL_TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    case (state_q)
      S_IDLE: if (req_valid) begin
        addr_d  = req_addr;
        wdata_d = req_wdata;
        mask_d  = dec_mask;
        state_d = dec_err ? S_RESP : req_we ? S_ISSUE_W : S_ISSUE_R;
      end
      S_ISSUE_R: state_d = S_CAPT;
      S_CAPT: begin
        valid_d = 1'b1;
        rdata_d = mem_read_data;
        state_d = S_IDLE;
      end
      S_ISSUE_W: begin
        seen_d  = 1'b0;
        cnt_d   = '0;
        state_d = S_WAIT_W;
      end
      S_WAIT_W: begin
        seen_d = seen_q | mem_clk_stall;
        cnt_d  = cnt_q + 1'b1;
        if (done || timeout) begin
          valid_d = 1'b1;
          err_d   = timeout;
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        valid_d = 1'b1;
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end
  assign req_ready      = state_q == S_IDLE;
  assign mem_memread    = state_q == S_ISSUE_R;
  assign mem_memwrite   = state_q == S_ISSUE_W;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_sign_mask  = mask_q;
  assign rsp_valid      = valid_q;
  assign rsp_err        = err_q;
  assign rsp_rdata      = rdata_q;
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: directed vectors against a behavioural data_mem with clk_stall writes
module tb_lsu_mem_initiator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, mem_addr, mem_write_data;
  logic [3:0]  mem_sign_mask;
  logic        mem_memread, mem_memwrite;
  logic [31:0] mem_read_data = '0;
  logic        mem_clk_stall = 1'b0;
  logic        no_stall = 1'b0;
  logic [31:0] m [0:255];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  lsu_mem_initiator #(.STALL_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_sign_mask(mem_sign_mask), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall)
  );
  function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [3:0] sm);
    logic [31:0] w, r;
    w = m[a[9:2]];
    r = sm[2:0] == 3'b001 ? {24'b0, w[a[1:0]*8 +: 8]} :
        sm[2:0] == 3'b011 ? {16'b0, w[a[1]*16 +: 16]} : w;
    if (sm[3] && sm[2:0] == 3'b001) r = {{24{r[7]}}, r[7:0]};
    if (sm[3] && sm[2:0] == 3'b011) r = {{16{r[15]}}, r[15:0]};
    return r;
  endfunction
  always @(posedge clk) begin
    if (mem_memread) mem_read_data <= mem_rd(mem_addr, mem_sign_mask);
    if (mem_clk_stall) begin
      mem_clk_stall <= 1'b0;
      if (mem_sign_mask[2:0] == 3'b001) m[mem_addr[9:2]][mem_addr[1:0]*8 +: 8] <= mem_write_data[7:0];
      if (mem_sign_mask[2:0] == 3'b011) m[mem_addr[9:2]][mem_addr[1]*16 +: 16] <= mem_write_data[15:0];
      if (mem_sign_mask[2:0] == 3'b111) m[mem_addr[9:2]] <= mem_write_data;
    end else if (mem_memwrite && !no_stall) mem_clk_stall <= 1'b1;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  mask;
    int          lo, hi, rd, wr;
  } vec_t;
  task automatic run(input vec_t v, input int idx);
    int lat = 0, nrd = 0, nwr = 0, both = 0;
    logic [3:0] sm;
    logic [31:0] sa;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    chk($sformatf("v%0d ready", idx), 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; sm = mem_sign_mask; sa = mem_addr;
    while (!rsp_valid && lat < 30) begin
      nrd += int'(mem_memread); nwr += int'(mem_memwrite);
      if (mem_memread && mem_memwrite) both++;
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("v%0d latency=%0d", idx, lat), 32'(lat >= v.lo && lat <= v.hi), 32'd1);
    chk($sformatf("v%0d err", idx), 32'(rsp_err), 32'(v.err));
    chk($sformatf("v%0d rdata", idx), rsp_rdata, v.rdata);
    chk($sformatf("v%0d read strobes", idx), 32'(nrd), 32'(v.rd));
    chk($sformatf("v%0d write strobes", idx), 32'(nwr), 32'(v.wr));
    chk($sformatf("v%0d strobe overlap", idx), 32'(both), 32'd0);
    chk($sformatf("v%0d ready with rsp", idx), 32'(req_ready), 32'd1);
    if (v.rd + v.wr > 0) begin
      chk($sformatf("v%0d sign_mask", idx), 32'(sm), 32'(v.mask));
      chk($sformatf("v%0d mem_addr", idx), sa, v.addr);
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d rsp one cycle", idx), 32'(rsp_valid), 32'd0);
  endtask
  vec_t vt [15];
  initial begin
    for (int i = 0; i < 256; i++) m[i] = '0;
    vt[0]  = '{1'b1, 3'b010, 32'h10,   32'h876543A1, 1'b0, 32'h0,        4'b0111, 4, 4, 0, 1};
    vt[1]  = '{1'b0, 3'b010, 32'h10,   32'h0,        1'b0, 32'h876543A1, 4'b0111, 3, 3, 1, 0};
    vt[2]  = '{1'b0, 3'b000, 32'h10,   32'h0,        1'b0, 32'hFFFFFFA1, 4'b1001, 3, 3, 1, 0};
    vt[3]  = '{1'b0, 3'b100, 32'h10,   32'h0,        1'b0, 32'h000000A1, 4'b0001, 3, 3, 1, 0};
    vt[4]  = '{1'b0, 3'b001, 32'h12,   32'h0,        1'b0, 32'hFFFF8765, 4'b1011, 3, 3, 1, 0};
    vt[5]  = '{1'b0, 3'b101, 32'h12,   32'h0,        1'b0, 32'h00008765, 4'b0011, 3, 3, 1, 0};
    vt[6]  = '{1'b0, 3'b010, 32'h12,   32'h0,        1'b1, 32'h0,        4'b0111, 2, 2, 0, 0};
    vt[7]  = '{1'b1, 3'b001, 32'h11,   32'h1234,     1'b1, 32'h0,        4'b0011, 2, 2, 0, 0};
    vt[8]  = '{1'b0, 3'b011, 32'h10,   32'h0,        1'b1, 32'h0,        4'b0111, 2, 2, 0, 0};
    vt[9]  = '{1'b1, 3'b100, 32'h10,   32'h0,        1'b1, 32'h0,        4'b0001, 2, 2, 0, 0};
    vt[10] = '{1'b1, 3'b000, 32'h13,   32'hFFFFFF55, 1'b0, 32'h0,        4'b0001, 4, 4, 0, 1};
    vt[11] = '{1'b0, 3'b100, 32'h13,   32'h0,        1'b0, 32'h00000055, 4'b0001, 3, 3, 1, 0};
    vt[12] = '{1'b0, 3'b010, 32'h10,   32'h0,        1'b0, 32'h556543A1, 4'b0111, 3, 3, 1, 0};
    vt[13] = '{1'b1, 3'b010, 32'h2000, 32'h1,        1'b0, 32'h0,        4'b0111, 4, 4, 0, 1};
    vt[14] = '{1'b0, 3'b010, 32'h2000, 32'h0,        1'b0, 32'h1,        4'b0111, 3, 3, 1, 0};
    #12;
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset strobes", {30'b0, mem_memread, mem_memwrite}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset sign_mask", 32'(mem_sign_mask), 32'd0);
    chk("reset rsp_rdata/err", rsp_rdata | 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 15; i++) run(vt[i], i);
    no_stall = 1'b1;
    run('{1'b1, 3'b010, 32'h30, 32'hDEADBEEF, 1'b1, 32'h0, 4'b0111, 8, 11, 0, 1}, 100);
    no_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h11223344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre-reset stall seen", 32'(mem_clk_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async reset strobes", {30'b0, mem_memread, mem_memwrite}, 32'd0);
    chk("async reset mem_addr", mem_addr, 32'd0);
    chk("async reset wdata", mem_write_data, 32'd0);
    chk("async reset sign_mask", 32'(mem_sign_mask), 32'd0);
    chk("async reset rdata/err", rsp_rdata | 32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("no rsp after reset %0d", i), 32'(rsp_valid), 32'd0);
    end
    run(vt[12], 200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
